// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue between MEM and the register file.
// Retires one head entry per cycle; exceptions/ERET pulse out of the head and flush the queue.
module wb_retire_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ms_to_ws_valid,
    output logic                     ws_allowin,
    input  logic [31:0]              ms_pc,
    input  logic                     ms_gr_we,
    input  logic [4:0]               ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic                     ms_ex,
    input  logic [4:0]               ms_excode,
    input  logic                     ms_bd,
    input  logic                     ms_eret,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [4:0]               ws_dest,
    output logic [DATA_W-1:0]        ws_dest_data,
    output logic                     ws_ex,
    output logic [4:0]               ws_excode,
    output logic [31:0]              ws_epc,
    output logic                     ws_bd,
    output logic                     ws_eret,
    output logic [$clog2(DEPTH):0]   ws_count,
    output logic [CNT_W-1:0]         retired_cnt,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int FW    = $clog2(FLUSH_CYC + 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FW-1:0]      r_flush_cnt;

    logic [31:0]        r_pc     [DEPTH];
    logic               r_gr_we  [DEPTH];
    logic [4:0]         r_dest   [DEPTH];
    logic [DATA_W-1:0]  r_result [DEPTH];
    logic               r_ex     [DEPTH];
    logic [4:0]         r_excode [DEPTH];
    logic               r_bd     [DEPTH];
    logic               r_eret   [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CNT_W-1:0]   r_retired;

    logic               w_in_run;
    logic               w_head_valid;
    logic               w_head_ex;
    logic               w_head_eret;
    logic               w_flush_evt;
    logic               w_retire;
    logic               w_push;
    logic               w_we;

    // Head decode: exception outranks ERET; both retire regardless of rf_stall.
    assign w_head_valid = (r_count != '0);
    assign w_head_ex    = w_head_valid && r_ex[r_rd_ptr];
    assign w_head_eret  = w_head_valid && !r_ex[r_rd_ptr] && r_eret[r_rd_ptr];
    assign w_flush_evt  = w_head_ex || w_head_eret;
    assign w_retire     = w_head_valid && (w_flush_evt || !rf_stall);
    assign w_we         = w_retire && !w_flush_evt && r_gr_we[r_rd_ptr];

    assign ws_allowin   = w_in_run && (r_count != CW'(DEPTH)) && !w_flush_evt;
    assign w_push       = ms_to_ws_valid && ws_allowin;

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_flush_evt) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_flush_cnt <= FW'(1)) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_in_run = (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_flush_cnt <= '0;
        end else if (w_flush_evt) begin
            r_flush_cnt <= FW'(FLUSH_CYC);
        end else if (r_state == S_FLUSH && r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Payload storage needs no reset: every consumer is gated by head validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]     <= ms_pc;
            r_gr_we[r_wr_ptr]  <= ms_gr_we;
            r_dest[r_wr_ptr]   <= ms_dest;
            r_result[r_wr_ptr] <= ms_result;
            r_ex[r_wr_ptr]     <= ms_ex;
            r_excode[r_wr_ptr] <= ms_excode;
            r_bd[r_wr_ptr]     <= ms_bd;
            r_eret[r_wr_ptr]   <= ms_eret;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_evt) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign rf_we             = w_we;
    assign rf_waddr          = w_we ? r_dest[r_rd_ptr] : 5'd0;
    assign rf_wdata          = w_we ? r_result[r_rd_ptr] : '0;

    assign ws_dest           = (w_head_valid && r_gr_we[r_rd_ptr]) ? r_dest[r_rd_ptr] : 5'd0;
    assign ws_dest_data      = w_head_valid ? r_result[r_rd_ptr] : '0;

    assign ws_ex             = w_head_ex;
    assign ws_excode         = w_head_ex ? r_excode[r_rd_ptr] : 5'd0;
    assign ws_epc            = w_head_ex ? r_pc[r_rd_ptr] : 32'd0;
    assign ws_bd             = w_head_ex && r_bd[r_rd_ptr];
    assign ws_eret           = w_head_eret;

    assign ws_count          = r_count;
    assign retired_cnt       = r_retired;

    assign debug_wb_pc       = w_retire ? r_pc[r_rd_ptr] : 32'd0;
    assign debug_wb_rf_wen   = {4{w_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: expected RF writes are queued at push and
// checked in order by a monitor whenever rf_we fires.
module tb_wb_retire_queue;

    logic        clk;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_ex;
    logic [4:0]  ms_excode;
    logic        ms_bd;
    logic        ms_eret;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_dest;
    logic [31:0] ws_dest_data;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_epc;
    logic        ws_bd;
    logic        ws_eret;
    logic [2:0]  ws_count;
    logic [31:0] retired_cnt;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t sb[$];

    wb_retire_queue #(
        .DATA_W   (32),
        .DEPTH    (4),
        .FLUSH_CYC(2),
        .CNT_W    (32)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ws_allowin       (ws_allowin),
        .ms_pc            (ms_pc),
        .ms_gr_we         (ms_gr_we),
        .ms_dest          (ms_dest),
        .ms_result        (ms_result),
        .ms_ex            (ms_ex),
        .ms_excode        (ms_excode),
        .ms_bd            (ms_bd),
        .ms_eret          (ms_eret),
        .rf_stall         (rf_stall),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .ws_dest          (ws_dest),
        .ws_dest_data     (ws_dest_data),
        .ws_ex            (ws_ex),
        .ws_excode        (ws_excode),
        .ws_epc           (ws_epc),
        .ws_bd            (ws_bd),
        .ws_eret          (ws_eret),
        .ws_count         (ws_count),
        .retired_cnt      (retired_cnt),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every RF write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && rf_we) begin
            wr_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got dest=%0d data=%h pc=%h, required no write",
                         rf_waddr, rf_wdata, debug_wb_pc);
            end else begin
                e = sb.pop_front();
                if ({rf_waddr, rf_wdata, debug_wb_pc} !== {e.dest, e.data, e.pc}) begin
                    bad++;
                    $display("FAIL write_order: got dest=%0d data=%h pc=%h, required dest=%0d data=%h pc=%h",
                             rf_waddr, rf_wdata, debug_wb_pc, e.dest, e.data, e.pc);
                end
            end
            total++;
            if (debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== rf_waddr || debug_wb_rf_wdata !== rf_wdata) begin
                bad++;
                $display("FAIL debug_wb: got wen=%h wnum=%0d wdata=%h, required wen=f wnum=%0d wdata=%h",
                         debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, rf_waddr, rf_wdata);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one MEM instruction for one cycle; expectation is queued only if accepted.
    task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [31:0] data, input logic ex, input logic [4:0] code,
                         input logic bd, input logic eret, input logic exp_wr, output logic acc);
        ms_to_ws_valid = 1'b1;
        ms_pc = pc; ms_gr_we = we; ms_dest = dest; ms_result = data;
        ms_ex = ex; ms_excode = code; ms_bd = bd; ms_eret = eret;
        acc = ws_allowin;
        if (acc && exp_wr) sb.push_back('{dest: dest, data: data, pc: pc});
        step(1);
        ms_to_ws_valid = 1'b0;
        ms_ex = 1'b0; ms_eret = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rf_stall = 1'b0; ms_to_ws_valid = 1'b0;
        ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_result = '0;
        ms_ex = 1'b0; ms_excode = '0; ms_bd = 1'b0; ms_eret = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);
        total++;
        if ({ws_allowin, rf_we, ws_ex, ws_eret, ws_count, retired_cnt, ws_dest, debug_wb_pc} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_state: got allowin=%b we=%b ex=%b eret=%b count=%0d ret=%0d dest=%0d, required 1 0 0 0 0 0 0",
                     ws_allowin, rf_we, ws_ex, ws_eret, ws_count, retired_cnt, ws_dest);
        end
    endtask

    task automatic test_single();
        logic acc;
        drive(32'hBFC0_0000, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
        total++;
        if ({acc, rf_we, rf_waddr, rf_wdata, ws_dest, ws_dest_data} !== {1'b1, 1'b1, 5'd3, 32'h1234, 5'd3, 32'h1234}) begin
            bad++;
            $display("FAIL single_write: got acc=%b we=%b waddr=%0d wdata=%h dest=%0d fwd=%h, required 1 1 3 1234 3 1234",
                     acc, rf_we, rf_waddr, rf_wdata, ws_dest, ws_dest_data);
        end
        step(1);
        total++;
        if (retired_cnt !== 32'd1 || ws_count !== 3'd0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL single_retire: got ret=%0d count=%0d we=%b, required 1 0 0", retired_cnt, ws_count, rf_we);
        end
    endtask

    task automatic test_stall_full();
        logic acc;
        rf_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
            total++;
            if (acc !== (i < 4)) begin
                bad++;
                $display("FAIL stall_accept[%0d]: got acc=%b, required %b", i, acc, (i < 4));
            end
        end
        total++;
        if (ws_count !== 3'd4 || ws_allowin !== 1'b0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL stall_full: got count=%0d allowin=%b we=%b, required 4 0 0", ws_count, ws_allowin, rf_we);
        end
        rf_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++;
            if (ws_count !== 3'(3 - i)) begin
                bad++;
                $display("FAIL drain_count[%0d]: got %0d, required %0d", i, ws_count, 3 - i);
            end
        end
        total++;
        if (retired_cnt !== 32'd5) begin
            bad++;
            $display("FAIL drain_retired: got %0d, required 5", retired_cnt);
        end
    endtask

    task automatic test_exception();
        logic acc;
        rf_stall = 1'b1;
        drive(32'h2000, 1'b1, 5'd7, 32'hAAAA, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
        drive(32'h2004, 1'b1, 5'd8, 32'hBBBB, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, acc);
        drive(32'h2008, 1'b1, 5'd9, 32'hCCCC, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, acc);
        rf_stall = 1'b0;
        #1;
        total++;
        if (rf_we !== 1'b1 || ws_ex !== 1'b0) begin
            bad++;
            $display("FAIL ex_before: got we=%b ex=%b, required 1 0", rf_we, ws_ex);
        end
        step(1);
        total++;
        if ({ws_ex, ws_excode, ws_epc, ws_bd, rf_we, ws_allowin, debug_wb_pc} !==
            {1'b1, 5'd8, 32'h2004, 1'b1, 1'b0, 1'b0, 32'h2004}) begin
            bad++;
            $display("FAIL ex_pulse: got ex=%b code=%0d epc=%h bd=%b we=%b allowin=%b dpc=%h, required 1 8 2004 1 0 0 2004",
                     ws_ex, ws_excode, ws_epc, ws_bd, rf_we, ws_allowin, debug_wb_pc);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (ws_ex !== 1'b0 || ws_count !== 3'd0 || ws_allowin !== (i == 2)) begin
                bad++;
                $display("FAIL ex_flush[%0d]: got ex=%b count=%0d allowin=%b, required 0 0 %b",
                         i, ws_ex, ws_count, ws_allowin, (i == 2));
            end
        end
        total++;
        if (retired_cnt !== 32'd7) begin
            bad++;
            $display("FAIL ex_retired: got %0d, required 7", retired_cnt);
        end
    endtask

    task automatic test_eret();
        logic acc;
        rf_stall = 1'b1;
        drive(32'h3000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
        total++;
        if ({ws_eret, ws_ex, rf_we, ws_allowin, debug_wb_pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h3000}) begin
            bad++;
            $display("FAIL eret_pulse: got eret=%b ex=%b we=%b allowin=%b dpc=%h, required 1 0 0 0 3000",
                     ws_eret, ws_ex, rf_we, ws_allowin, debug_wb_pc);
        end
        step(1);
        total++;
        if (ws_eret !== 1'b0 || ws_count !== 3'd0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL eret_after: got eret=%b count=%0d we=%b, required 0 0 0", ws_eret, ws_count, rf_we);
        end
        step(2);
        rf_stall = 1'b0;
        total++;
        if (ws_allowin !== 1'b1 || retired_cnt !== 32'd8) begin
            bad++;
            $display("FAIL eret_recover: got allowin=%b ret=%0d, required 1 8", ws_allowin, retired_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(32'h4000 + 32'(i * 4), 1'b1, 5'(10 + i), 32'hD000 + 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
        rf_stall = 1'b0;
        drive(32'h4010, 1'b1, 5'd14, 32'hE000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
        total++;
        if (acc !== 1'b0 || ws_count !== 3'd3) begin
            bad++;
            $display("FAIL full_no_passthru: got acc=%b count=%0d, required 0 3", acc, ws_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h4010 + 32'(i * 4), 1'b1, 5'(14 + i), 32'hE000 + 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
            total++;
            if (acc !== 1'b1 || ws_count !== 3'd3) begin
                bad++;
                $display("FAIL push_pop[%0d]: got acc=%b count=%0d, required 1 3", i, acc, ws_count);
            end
        end
        step(3);
        total++;
        if (ws_count !== 3'd0 || retired_cnt !== 32'd15 || sb.size() != 0) begin
            bad++;
            $display("FAIL wrap_drain: got count=%0d ret=%0d pending=%0d, required 0 15 0",
                     ws_count, retired_cnt, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic acc;
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(32'h5000 + 32'(i * 4), 1'b1, 5'(20 + i), 32'hF000 + 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, acc);
        total++;
        if (ws_count !== 3'd3 || ws_dest !== 5'd20) begin
            bad++;
            $display("FAIL pre_reset: got count=%0d dest=%0d, required 3 20", ws_count, ws_dest);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({ws_allowin, rf_we, ws_count, retired_cnt, ws_dest, ws_dest_data, debug_wb_pc, ws_ex, ws_eret} !==
            {1'b1, 1'b0, 3'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midflight_reset: got allowin=%b we=%b count=%0d ret=%0d dest=%0d fwd=%h, required 1 0 0 0 0 0",
                     ws_allowin, rf_we, ws_count, retired_cnt, ws_dest, ws_dest_data);
        end
        step(1);
        resetn = 1'b1;
        rf_stall = 1'b0;
        step(4);
        total++;
        if (ws_count !== 3'd0 || retired_cnt !== 32'd0 || ws_ex !== 1'b0 || ws_eret !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got count=%0d ret=%0d ex=%b eret=%b, required 0 0 0 0",
                     ws_count, retired_cnt, ws_ex, ws_eret);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_full();
        test_exception();
        test_eret();
        test_back_to_back();
        test_reset_midflight();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
